// File: rtl/rs_pkg.sv
// Shared helpers for the pipelined FIFO link.
//   clog2 : ceiling log2, sizes pointers and counters
//   grace : beats that can still arrive after full_n falls, for a given number
//           of register stages on each direction of the link
package rs_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

  // One stage forward, one stage back per pipeline level, plus the beat
  // already launched on the edge where full_n is first seen low.
  function automatic int unsigned grace(input int unsigned pipe_level);
    return 2 * pipe_level + 1;
  endfunction

endpackage

// File: rtl/rs_sink_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
module rs_sink_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; only entries covered by the count are ever observed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rs_pipelined_sink_fifo.sv
// Receiving end of a pipelined FIFO handshake link. Stores every in-flight
// beat, lowers if_full_n early enough to absorb the beats still in the
// upstream register stages, and presents a first-word-fall-through interface.
// Ports:
//   clk         clock, all logic on posedge
//   reset       synchronous active-high reset
//   if_full_n   registered space-available flag toward the producer pipeline
//   if_write    beat valid from the upstream pipeline
//   if_din      beat payload
//   if_empty_n  data available (combinational from the entry count)
//   if_read     consumer pops the head entry
//   if_dout     head entry, valid while if_empty_n=1
//   overflow    sticky dropped-beat flag
// Configuration macro RS_SINK_OVF_FLAG_EN: when defined, overflow records a
// dropped beat until reset (and simulation reports it); otherwise overflow is 0.
module rs_pipelined_sink_fifo
  import rs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PIPE_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  overflow
);

  localparam int unsigned GRACE = grace(PIPE_LEVEL);
  localparam int unsigned AW    = clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;

  // Elaboration-time guard on the geometry
  if (((1 << AW) != DEPTH) || (DEPTH <= GRACE)) begin : g_bad_cfg
    $error("rs_pipelined_sink_fifo: DEPTH must be a power of 2 and > GRACE");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_read;
  logic          accept;
  logic          drop;

  // Accept/read decisions; a read frees a slot for a same-cycle write when full
  always_comb begin
    do_read    = if_read && (count != '0);
    accept     = if_write && ((count < CW'(DEPTH)) || do_read);
    drop       = if_write && !accept;
    count_next = count + CW'(accept) - CW'(do_read);
  end

  // Pointers, occupancy and the registered space flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      if_full_n <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_next;
      if_full_n <= (count_next < CW'(DEPTH - GRACE));
    end
  end

  assign if_empty_n = (count != '0);

  rs_sink_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (accept && !reset),
    .waddr (wr_ptr),
    .wdata (if_din),
    .raddr (rd_ptr),
    .rdata (if_dout)
  );

`ifdef RS_SINK_OVF_FLAG_EN
  // Sticky record of a beat lost at full occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && drop) begin
      $error("rs_pipelined_sink_fifo: beat dropped at full occupancy");
    end
  end
`endif
`else
  assign overflow = 1'b0;
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
